// File: rtl/inverse_nr_seq.sv
// Sequential |1/det| unit: linear seed plus ITER Newton-Raphson steps on one shared multiplier.
// Latency: out_valid rises 2*ITER+3 cycles after the accepting edge, for every input.
// Backpressure: one item in flight; in_ready only in IDLE, and the result is held in DONE until out_ready.
// Optional: define INVERSE_ZERO_DETECT_EN to add out_zero and a saturated result for det==0.
module inverse_nr_seq #(
    parameter int IN_W   = 13,
    parameter int FRAC_W = 23,
    parameter int ITER   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_det,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FRAC_W:0]        out_inv,
    output logic                   out_negative,
    output logic                   busy
`ifdef INVERSE_ZERO_DETECT_EN
    ,
    output logic                   out_zero
`endif
);

    localparam int YW = FRAC_W + 2;
    localparam int PW = $clog2(IN_W + 1);
    localparam int CW = $clog2(ITER + 1);

    // Seed constants 48/17 and 32/17, rounded to nearest at FRAC_W fractional bits.
    localparam logic [YW-1:0] K1  = YW'(((64'd96 << FRAC_W) + 64'd17) / 64'd34);
    localparam logic [YW-1:0] K2  = YW'(((64'd64 << FRAC_W) + 64'd17) / 64'd34);
    localparam logic [YW-1:0] TWO = {2'b10, {FRAC_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_SEED,
        S_ITER_T,
        S_ITER_Y,
        S_SCALE,
        S_DONE
    } state_t;

    state_t            state;
    logic [IN_W-1:0]   det_r;
    logic [PW-1:0]     p_r;
    logic [FRAC_W-1:0] m_r;
    logic [YW-1:0]     y_r;
    logic [YW-1:0]     t_r;
    logic [CW-1:0]     iter_cnt;
`ifdef INVERSE_ZERO_DETECT_EN
    logic              zero_r;
`endif

    function automatic logic [PW-1:0] bit_len(input logic [IN_W-1:0] v);
        bit_len = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (v[i]) bit_len = PW'(i + 1);
        end
    endfunction

    // Magnitude as IN_W-bit unsigned so the most negative input maps to 2^(IN_W-1).
    logic [IN_W-1:0]        mag;
    logic [PW-1:0]          p_next;
    logic [IN_W+FRAC_W-1:0] norm_ext;

    assign mag      = det_r[IN_W-1] ? (~det_r + {{(IN_W-1){1'b0}}, 1'b1}) : det_r;
    assign p_next   = bit_len(mag);
    assign norm_ext = {mag, {FRAC_W{1'b0}}} >> p_next;

    logic [YW-1:0]   mul_a;
    logic [YW-1:0]   mul_b;
    logic [2*YW-1:0] prod;
    logic [YW-1:0]   prod_q;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_SEED: begin
                mul_a = K2;
                mul_b = {2'b00, m_r};
            end
            S_ITER_T: begin
                mul_a = {2'b00, m_r};
                mul_b = y_r;
            end
            S_ITER_Y: begin
                mul_a = y_r;
                mul_b = TWO - t_r;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    assign prod   = mul_a * mul_b;
    assign prod_q = prod[FRAC_W +: YW];

    logic unused_bits;
    assign unused_bits = ^{prod[FRAC_W-1:0], prod[2*YW-1:FRAC_W+YW],
                           norm_ext[IN_W+FRAC_W-1:FRAC_W]};

    // y reaches exactly 2.0 for power-of-two magnitudes; saturate to the Q1 range.
    logic [FRAC_W:0] y_clamp;
    assign y_clamp = y_r[YW-1] ? {(FRAC_W+1){1'b1}} : y_r[FRAC_W:0];

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            det_r        <= '0;
            p_r          <= '0;
            m_r          <= '0;
            y_r          <= '0;
            t_r          <= '0;
            iter_cnt     <= '0;
            out_valid    <= 1'b0;
            out_inv      <= '0;
            out_negative <= 1'b0;
`ifdef INVERSE_ZERO_DETECT_EN
            zero_r       <= 1'b0;
            out_zero     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        det_r        <= in_det;
                        out_negative <= in_det[IN_W-1];
                        state        <= S_NORM;
                    end
                end
                S_NORM: begin
                    p_r   <= p_next;
                    m_r   <= norm_ext[FRAC_W-1:0];
`ifdef INVERSE_ZERO_DETECT_EN
                    zero_r <= (mag == '0);
`endif
                    state <= S_SEED;
                end
                S_SEED: begin
                    y_r      <= K1 - prod_q;
                    iter_cnt <= '0;
                    state    <= S_ITER_T;
                end
                S_ITER_T: begin
                    t_r   <= prod_q;
                    state <= S_ITER_Y;
                end
                S_ITER_Y: begin
                    y_r      <= prod_q;
                    iter_cnt <= iter_cnt + CW'(1);
                    state    <= (iter_cnt == CW'(ITER - 1)) ? S_SCALE : S_ITER_T;
                end
                S_SCALE: begin
`ifdef INVERSE_ZERO_DETECT_EN
                    if (zero_r) begin
                        out_inv      <= '1;
                        out_zero     <= 1'b1;
                        out_negative <= 1'b0;
                    end else begin
                        out_inv  <= y_clamp >> p_r;
                        out_zero <= 1'b0;
                    end
`else
                    out_inv <= y_clamp >> p_r;
`endif
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inverse_nr_seq.sv
// Directed bench for inverse_nr_seq at default parameters (IN_W=13, FRAC_W=23, ITER=3).
module tb_inverse_nr_seq;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [12:0] in_det;
    logic               out_valid;
    logic               out_ready;
    logic [23:0]        out_inv;
    logic               out_negative;
    logic               busy;
`ifdef INVERSE_ZERO_DETECT_EN
    logic               out_zero;
`endif

    int total;
    int bad;

    inverse_nr_seq dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_det       (in_det),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inv      (out_inv),
        .out_negative (out_negative),
        .busy         (busy)
`ifdef INVERSE_ZERO_DETECT_EN
        ,
        .out_zero     (out_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one transaction; lat is edges from accept to out_valid, -1 on timeout.
    task automatic run_op(input logic signed [12:0] det, output logic [23:0] inv,
                          output logic neg, output int lat);
        int n;
        lat = -1;
        @(negedge clk);
        in_det   = det;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        inv = out_inv;
        neg = out_negative;
        if (lat > 0 && out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int abs_err(input logic [23:0] inv, input int expv);
        int e;
        e = int'(inv) - expv;
        return (e < 0) ? -e : e;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (out_inv !== 24'h0) begin bad++; $display("FAIL reset_out_inv got=%h want=000000", out_inv); end
        total++; if (out_negative !== 1'b0) begin bad++; $display("FAIL reset_out_negative got=%b want=0", out_negative); end
`ifdef INVERSE_ZERO_DETECT_EN
        total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL reset_out_zero got=%b want=0", out_zero); end
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_directed();
        logic signed [12:0] dets [8];
        int                 exps [8];
        logic               negs [8];
        logic [23:0]        inv;
        logic               neg;
        int                 lat;
        dets = '{13'sd1, -13'sd4, -13'sd4096, 13'sd3, 13'sd3072, -13'sd1, 13'sd4095, 13'sd5};
        exps = '{8388608, 2097152, 2048, 2796202, 2730, 8388608, 2048, 1677721};
        negs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_op(dets[i], inv, neg, lat);
            total++; if (lat != 9) begin bad++; $display("FAIL dir_latency det=%0d got=%0d want=9", dets[i], lat); end
            total++; if (abs_err(inv, exps[i]) > 8) begin bad++; $display("FAIL dir_value det=%0d got=%0d want=%0d+-8", dets[i], inv, exps[i]); end
            total++; if (neg !== negs[i]) begin bad++; $display("FAIL dir_negative det=%0d got=%b want=%b", dets[i], neg, negs[i]); end
        end
    endtask

    task automatic test_sweep();
        logic [23:0] inv;
        logic        neg;
        int          lat;
        int          expv;
        int          mag;
        for (int d = -4096; d <= 4095; d += 5) begin
            if (d != 0) begin
                mag  = (d < 0) ? -d : d;
                expv = (1 << 23) / mag;
                run_op(13'(d), inv, neg, lat);
                total++;
                if (lat != 9 || abs_err(inv, expv) > 8 || neg !== (d < 0)) begin
                    bad++;
                    $display("FAIL sweep det=%0d got=%0d neg=%b lat=%0d want=%0d+-8 neg=%b lat=9",
                             d, inv, neg, lat, expv, (d < 0));
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [23:0] inv;
        logic        neg;
        int          lat;
        out_ready = 1'b0;
        run_op(-13'sd7, inv, neg, lat);
        total++; if (lat != 9) begin bad++; $display("FAIL hold_latency got=%0d want=9", lat); end
        total++; if (abs_err(inv, 1198372) > 8) begin bad++; $display("FAIL hold_value got=%0d want=1198372+-8", inv); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_inv !== inv || out_negative !== 1'b1 ||
                in_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL hold_stable cyc=%0d got v=%b inv=%h neg=%b rdy=%b busy=%b want v=1 inv=%h neg=1 rdy=0 busy=1",
                         c, out_valid, out_inv, out_negative, in_ready, busy, inv);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] inv;
        logic        neg;
        int          lat;
        @(negedge clk);
        in_det   = 13'sd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Five edges after accept the FSM sits in ITER_Y of the second iteration.
        repeat (5) @(posedge clk);
        #3;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
        reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (out_inv !== 24'h0) begin bad++; $display("FAIL midrst_out_inv got=%h want=000000", out_inv); end
        @(negedge clk);
        reset = 1'b0;
        run_op(13'sd5, inv, neg, lat);
        total++; if (lat != 9) begin bad++; $display("FAIL midrst_next_latency got=%0d want=9", lat); end
        total++; if (abs_err(inv, 1677721) > 8 || neg !== 1'b0) begin bad++; $display("FAIL midrst_next_value got=%0d neg=%b want=1677721+-8 neg=0", inv, neg); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        in_det   = 13'sd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        // in_valid stays high with a new det while busy; it must be ignored until IDLE.
        in_det = 13'sd100;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy_ready got=%b want=0", in_ready); end
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin lat = c; break; end
        end
        total++; if (lat != 9) begin bad++; $display("FAIL b2b_first_latency got=%0d want=9", lat); end
        total++; if (abs_err(out_inv, 1398101) > 8) begin bad++; $display("FAIL b2b_first_value got=%0d want=1398101+-8", out_inv); end
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin lat = c; break; end
        end
        total++; if (lat != 9) begin bad++; $display("FAIL b2b_second_latency got=%0d want=9", lat); end
        total++; if (abs_err(out_inv, 83886) > 8 || out_negative !== 1'b0) begin bad++; $display("FAIL b2b_second_value got=%0d neg=%b want=83886+-8 neg=0", out_inv, out_negative); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero();
        logic [23:0] inv;
        logic        neg;
        int          lat;
        run_op(13'sd0, inv, neg, lat);
        total++; if (lat != 9) begin bad++; $display("FAIL zero_latency got=%0d want=9", lat); end
`ifdef INVERSE_ZERO_DETECT_EN
        total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL zero_flag got=%b want=1", out_zero); end
        total++; if (inv !== 24'hFFFFFF) begin bad++; $display("FAIL zero_inv got=%h want=ffffff", inv); end
        total++; if (neg !== 1'b0) begin bad++; $display("FAIL zero_negative got=%b want=0", neg); end
`endif
        run_op(13'sd7, inv, neg, lat);
        total++; if (abs_err(inv, 1198372) > 8 || lat != 9) begin bad++; $display("FAIL zero_next_value got=%0d lat=%0d want=1198372+-8 lat=9", inv, lat); end
`ifdef INVERSE_ZERO_DETECT_EN
        total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL nonzero_flag got=%b want=0", out_zero); end
`endif
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_det    = '0;
        out_ready = 1'b1;
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_zero();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
